// File: rtl/main_mem_arb_if.sv
// Bus bundle linking the fetch and memory-access requesters, the arbiter and main memory.
// The arbiter takes the slave view; requesters and memory together take the master view.
interface main_mem_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdat;

  logic        ma_req;
  logic        ma_wen;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdat;
  logic        ma_gnt;
  logic        ma_rvalid;
  logic [31:0] ma_rdat;

  logic        mem_cs;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dat_in;
  logic [31:0] mem_dat_out;

  modport slave (
    input  if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    output if_gnt, if_rvalid, if_rdat, ma_gnt, ma_rvalid, ma_rdat,
           mem_cs, mem_wen, mem_addr, mem_dat_in
  );

  modport master (
    output if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    input  if_gnt, if_rvalid, if_rdat, ma_gnt, ma_rvalid, ma_rdat,
           mem_cs, mem_wen, mem_addr, mem_dat_in
  );
endinterface

// File: rtl/main_mem_arb.sv
// Single-port main-memory arbiter: memory-access wins by default, fetch is forced through
// after STARVE_MAX consecutive denials; read data is routed back one cycle after the grant.
module main_mem_arb #(
  parameter int MAIN_MEM_BYTE_ADD_W = 8,
  parameter int STARVE_MAX          = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  main_mem_arb_if.slave                      bus,
  output logic [$clog2(STARVE_MAX+1)-1:0]    arb_starve_cnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || MAIN_MEM_BYTE_ADD_W < 1 || MAIN_MEM_BYTE_ADD_W > 32)
  begin : g_badParams
    $error("main_mem_arb: parameter out of range");
  end

  typedef enum logic [1:0] {RD_NONE, RD_IF, RD_MA} rdOwn_t;

  rdOwn_t          r_rdOwn;
  logic [CW-1:0]   r_starveCnt;

  logic            w_forced;
  logic            w_ifGnt;
  logic            w_maGnt;
  logic            w_ifRvalid;
  logic            w_maRvalid;

  assign w_forced = (r_starveCnt == CW'(STARVE_MAX)) & bus.if_req;
  assign w_maGnt  = ~rst & bus.ma_req & ~w_forced;
  assign w_ifGnt  = ~rst & bus.if_req & ~w_maGnt;

  // Gating with rst drops a read that was in flight when reset arrived.
  assign w_ifRvalid = ~rst & (r_rdOwn == RD_IF);
  assign w_maRvalid = ~rst & (r_rdOwn == RD_MA);

  assign bus.if_gnt    = w_ifGnt;
  assign bus.ma_gnt    = w_maGnt;
  assign bus.if_rvalid = w_ifRvalid;
  assign bus.ma_rvalid = w_maRvalid;
  assign bus.if_rdat   = w_ifRvalid ? bus.mem_dat_out : 32'h0;
  assign bus.ma_rdat   = w_maRvalid ? bus.mem_dat_out : 32'h0;
  assign arb_starve_cnt = rst ? '0 : r_starveCnt;

  always_comb begin
    bus.mem_cs     = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_dat_in = 32'h0;
    if (w_maGnt) begin
      bus.mem_cs     = 1'b1;
      bus.mem_wen    = bus.ma_wen;
      bus.mem_addr   = bus.ma_addr;
      bus.mem_dat_in = bus.ma_wdat;
    end else if (w_ifGnt) begin
      bus.mem_cs     = 1'b1;
      bus.mem_addr   = bus.if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= '0;
      r_rdOwn     <= RD_NONE;
    end else begin
      if (bus.if_req & ~w_ifGnt) begin
        if (r_starveCnt != CW'(STARVE_MAX)) r_starveCnt <= r_starveCnt + CW'(1);
      end else begin
        r_starveCnt <= '0;
      end

      if (w_ifGnt)                      r_rdOwn <= RD_IF;
      else if (w_maGnt & ~bus.ma_wen)   r_rdOwn <= RD_MA;
      else                              r_rdOwn <= RD_NONE;
    end
  end

endmodule
